// File: rtl/i2s_pkg.sv
// Shared encodings for the I2S sample buffer: FSM state values and default sample width.
package i2s_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } i2s_state_e;

    localparam int DEFAULT_WORD_SIZE = 24;

endpackage

// File: rtl/stereo_fifo.sv
// Dual-pointer RAM holding {left, right} stereo pairs; read data is the entry at the read pointer.
module stereo_fifo #(
    parameter int WORD_SIZE = 24,
    parameter int DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   wr_en,
    input  logic [2*WORD_SIZE-1:0] wr_data,
    input  logic                   rd_en,
    output logic [2*WORD_SIZE-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [2*WORD_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    // Storage is deliberately left out of reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/i2s_sample_buffer.sv
// Stereo sample buffer between a synth core and an I2S transmitter, popping one pair per frame edge.
// Optional macro I2S_BUF_UNDERRUN_MUTE_EN: outputs go to 0 on underrun instead of repeating the last pair.
module i2s_sample_buffer
    import i2s_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         nReset,
    input  logic [WORD_SIZE-1:0]         in_left,
    input  logic [WORD_SIZE-1:0]         in_right,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         lrclk,
    output logic [WORD_SIZE-1:0]         left_data,
    output logic [WORD_SIZE-1:0]         right_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         underrun,
    input  logic                         clear_underrun,
    output i2s_state_e                   dbg_state
);

    // Input handshake: a pair is taken on a rising clk edge when in_valid && in_ready;
    // in_ready depends only on the registered level, never on a same-cycle pop.

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);

    i2s_state_e             state;
    logic                   lrclk_q;
    logic                   frame_edge;
    logic                   push;
    logic                   pop;
    logic                   underrun_ev;
    logic [2*WORD_SIZE-1:0] rd_pair;

    assign in_ready    = (level != FULL);
    assign frame_edge  = lrclk & ~lrclk_q;
    assign push        = in_valid & in_ready;
    // Priming pops the first pair on the same edge that starts RUN.
    assign pop         = frame_edge & ((state == RUN) ? (level != '0) : (level >= HALF));
    assign underrun_ev = frame_edge & (state == RUN) & (level == '0);
    assign dbg_state   = state;

    stereo_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nReset  (nReset),
        .wr_en   (push),
        .wr_data ({in_left, in_right}),
        .rd_en   (pop),
        .rd_data (rd_pair)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            level <= '0;
        end else if (push && !pop) begin
            level <= level + 1'b1;
        end else if (pop && !push) begin
            level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= PRIME;
            lrclk_q    <= 1'b0;
            left_data  <= '0;
            right_data <= '0;
            underrun   <= 1'b0;
        end else begin
            lrclk_q <= lrclk;
            // A fresh underrun outranks a clear request in the same cycle.
            if (underrun_ev) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end
            case (state)
                PRIME: begin
                    if (pop) begin
                        state      <= RUN;
                        left_data  <= rd_pair[2*WORD_SIZE-1 -: WORD_SIZE];
                        right_data <= rd_pair[WORD_SIZE-1:0];
                    end
                end
                RUN: begin
                    if (pop) begin
                        left_data  <= rd_pair[2*WORD_SIZE-1 -: WORD_SIZE];
                        right_data <= rd_pair[WORD_SIZE-1:0];
                    end else if (underrun_ev) begin
                        state <= PRIME;
`ifdef I2S_BUF_UNDERRUN_MUTE_EN
                        left_data  <= '0;
                        right_data <= '0;
`endif
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_sample_buffer.sv
// Self-checking bench for i2s_sample_buffer: queue-based reference model plus directed and random stimulus.
module tb_i2s_sample_buffer;
    import i2s_pkg::*;

    localparam int W     = 24;
    localparam int DEPTH = 8;
`ifdef I2S_BUF_UNDERRUN_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]          in_left = '0, in_right = '0;
    logic                  in_valid = 1'b0, lrclk = 1'b0, clear_underrun = 1'b0;
    logic                  in_ready, underrun;
    logic [W-1:0]          left_data, right_data;
    logic [$clog2(DEPTH):0] level;
    i2s_state_e            dbg_state;

    i2s_sample_buffer #(.WORD_SIZE(W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .nReset         (nReset),
        .in_left        (in_left),
        .in_right       (in_right),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .lrclk          (lrclk),
        .left_data      (left_data),
        .right_data     (right_data),
        .level          (level),
        .underrun       (underrun),
        .clear_underrun (clear_underrun),
        .dbg_state      (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2*W-1:0] mq[$];
    logic           m_run = 1'b0, m_lrq = 1'b0, m_und = 1'b0;
    logic [W-1:0]   m_l = '0, m_r = '0;

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mq.delete();
            m_run = 1'b0; m_lrq = 1'b0; m_und = 1'b0; m_l = '0; m_r = '0;
        end else begin
            bit fe, acc, und_ev;
            logic [2*W-1:0] p;
            acc    = in_valid && (mq.size() != DEPTH);
            fe     = lrclk && !m_lrq;
            m_lrq  = lrclk;
            und_ev = 1'b0;
            if (fe) begin
                if (!m_run) begin
                    if (mq.size() >= DEPTH / 2) begin
                        m_run = 1'b1;
                        p = mq.pop_front();
                        m_l = p[2*W-1:W]; m_r = p[W-1:0];
                    end
                end else if (mq.size() > 0) begin
                    p = mq.pop_front();
                    m_l = p[2*W-1:W]; m_r = p[W-1:0];
                end else begin
                    und_ev = 1'b1;
                    m_run  = 1'b0;
                    if (MUTE) begin m_l = '0; m_r = '0; end
                end
            end
            if (acc) mq.push_back({in_left, in_right});
            if (und_ev) m_und = 1'b1;
            else if (clear_underrun) m_und = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (nReset) begin
            chk("m_level",    32'(level),      32'(mq.size()));
            chk("m_in_ready", 32'(in_ready),   32'(mq.size() != DEPTH));
            chk("m_left",     32'(left_data),  32'(m_l));
            chk("m_right",    32'(right_data), 32'(m_r));
            chk("m_underrun", 32'(underrun),   32'(m_und));
            chk("m_state",    32'(dbg_state),  32'(m_run));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic v, input logic [W-1:0] l, input logic [W-1:0] r,
                       input logic lr, input logic clr = 1'b0);
        in_valid = v; in_left = l; in_right = r; lrclk = lr; clear_underrun = clr;
        @(negedge clk);
    endtask

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] e;

    initial begin
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        chk("rst_level",    32'(level),     32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd1);
        chk("rst_left",     32'(left_data), 32'd0);
        chk("rst_underrun", 32'(underrun),  32'd0);
        chk("rst_state",    32'(dbg_state), 32'(PRIME));

        // Prime with 4 pairs, first frame edge starts RUN and pops pair 1.
        for (int i = 1; i <= 4; i++) cyc(1'b1, W'(i), W'(24'h800000 + i), 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        chk("first_left",  32'(left_data),  32'h000001);
        chk("first_right", 32'(right_data), 32'h800001);
        chk("first_state", 32'(dbg_state),  32'(RUN));
        chk("first_level", 32'(level),      32'd3);
        for (int k = 2; k <= 4; k++) begin
            cyc(1'b0, '0, '0, 1'b1);
            cyc(1'b0, '0, '0, 1'b0);
            cyc(1'b0, '0, '0, 1'b0);
            cyc(1'b0, '0, '0, 1'b1);
            chk("seq_left",  32'(left_data),  32'(k));
            chk("seq_right", 32'(right_data), 32'(24'h800000 + k));
        end

        // Run dry: next edge underruns.
        cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        chk("und_flag",  32'(underrun),   32'd1);
        chk("und_state", 32'(dbg_state),  32'(PRIME));
        chk("und_left",  32'(left_data),  MUTE ? 32'd0 : 32'h000004);
        chk("und_right", 32'(right_data), MUTE ? 32'd0 : 32'h800004);
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        chk("und_clear", 32'(underrun), 32'd0);
        cyc(1'b0, '0, '0, 1'b0);

        // Fill to full; 9th pair refused.
        for (int i = 1; i <= 8; i++) cyc(1'b1, W'(24'h100 + i), W'(24'h200 + i), 1'b0);
        chk("full_level", 32'(level),    32'd8);
        chk("full_ready", 32'(in_ready), 32'd0);
        cyc(1'b1, W'(24'habc), W'(24'habd), 1'b0);
        chk("ninth_level", 32'(level), 32'd8);
        // Push while full on a frame edge: push refused, pop happens.
        cyc(1'b1, W'(24'hdef), W'(24'h123), 1'b1);
        chk("fullpp_level", 32'(level),     32'd7);
        chk("fullpp_left",  32'(left_data), 32'h000101);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, '0, '0, 1'b0);
            cyc(1'b0, '0, '0, 1'b1);
        end
        chk("drain_level", 32'(level), 32'd3);
        cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b1, W'(24'h555), W'(24'h666), 1'b1);
        chk("pp3_level", 32'(level),     32'd3);
        chk("pp3_left",  32'(left_data), 32'h000106);

        // Level 5 then asynchronous reset mid-frame.
        cyc(1'b1, W'(24'h777), W'(24'h888), 1'b0);
        cyc(1'b1, W'(24'h999), W'(24'haaa), 1'b0);
        chk("pre_rst_level", 32'(level), 32'd5);
        #3 nReset = 1'b0;
        #1;
        chk("arst_level", 32'(level),      32'd0);
        chk("arst_ready", 32'(in_ready),   32'd1);
        chk("arst_left",  32'(left_data),  32'd0);
        chk("arst_right", 32'(right_data), 32'd0);
        chk("arst_state", 32'(dbg_state),  32'(PRIME));
        in_valid = 1'b0; lrclk = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
        cyc(1'b0, '0, '0, 1'b0);

        // 100 frames, one push per frame, through pointer wrap; outputs follow input order.
        for (int i = 0; i < 4; i++) begin
            e = {W'($urandom), W'($urandom)};
            exp_q.push_back(e);
            cyc(1'b1, e[2*W-1:W], e[W-1:0], 1'b0);
        end
        for (int f = 0; f < 100; f++) begin
            e = {W'($urandom), W'($urandom)};
            exp_q.push_back(e);
            cyc(1'b1, e[2*W-1:W], e[W-1:0], 1'b0);
            repeat (3) cyc(1'b0, '0, '0, 1'b0);
            cyc(1'b0, '0, '0, 1'b1);
            e = exp_q.pop_front();
            chk("stream_pair", 32'({left_data, right_data} == e), 32'd1);
            repeat (3) cyc(1'b0, '0, '0, 1'b1);
        end
        chk("stream_no_underrun", 32'(underrun), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            cyc(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
